// File: rtl/mouse_slave_sm_pkg.sv
// ============================================================================
//  Module   : mouse_slave_sm_pkg
//  Purpose  : Shared definitions for the PS/2 mouse device-side protocol
//             engine: host command codes, device responses, device IDs,
//             IntelliMouse knock rates and the controller state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mouse_slave_sm_pkg;

    // Host commands
    localparam logic [7:0] c_cmd_reset        = 8'hFF;
    localparam logic [7:0] c_cmd_set_defaults = 8'hF6;
    localparam logic [7:0] c_cmd_disable      = 8'hF5;
    localparam logic [7:0] c_cmd_enable       = 8'hF4;
    localparam logic [7:0] c_cmd_set_rate     = 8'hF3;
    localparam logic [7:0] c_cmd_get_id       = 8'hF2;

    // Device responses
    localparam logic [7:0] c_rsp_ack          = 8'hFA;
    localparam logic [7:0] c_rsp_resend       = 8'hFE;
    localparam logic [7:0] c_rsp_bat_ok       = 8'hAA;

    // Device IDs
    localparam logic [7:0] c_id_std           = 8'h00;
    localparam logic [7:0] c_id_intelli       = 8'h03;

    // Sample-rate "knock" that unlocks the wheel protocol: 200, 100, 80
    localparam logic [7:0] c_knock_rate_1     = 8'hC8;
    localparam logic [7:0] c_knock_rate_2     = 8'h64;
    localparam logic [7:0] c_knock_rate_3     = 8'h50;

    localparam logic [7:0] c_default_rate     = 8'h64;

    typedef enum logic [2:0] {
        ST_PWRUP      = 3'd0,
        ST_SEND       = 3'd1,
        ST_WAIT_SENT  = 3'd2,
        ST_IDLE       = 3'd3,
        ST_AWAIT_RATE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mouse_slave_sm_knock_detect.sv
// ============================================================================
//  Module   : mouse_knock_detect
//  Purpose  : Tracks accepted sample-rate values and flags the 200/100/80
//             sequence that switches the mouse into IntelliMouse mode.
//             Only present when MOUSE_SLAVE_INTELLIMOUSE_EN is defined.
//  Ports    : CLK, RESET       - clock, synchronous active-high reset
//             i_clear          - any non-set-rate host command
//             i_rate_valid     - a good sample rate was accepted this cycle
//             i_rate           - the accepted sample rate
//             o_detect         - 1-cycle pulse on completing the sequence
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef MOUSE_SLAVE_INTELLIMOUSE_EN
module mouse_knock_detect
    import mouse_slave_sm_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       i_clear,
    input  logic       i_rate_valid,
    input  logic [7:0] i_rate,
    output logic       o_detect
);

    logic [1:0] r_idx;
    logic [1:0] w_idx_nxt;
    logic       w_detect;

    always_comb begin
        w_idx_nxt = r_idx;
        w_detect  = 1'b0;
        if (i_clear) begin
            w_idx_nxt = 2'd0;
        end else if (i_rate_valid) begin
            if (r_idx == 2'd0 && i_rate == c_knock_rate_1) begin
                w_idx_nxt = 2'd1;
            end else if (r_idx == 2'd1 && i_rate == c_knock_rate_2) begin
                w_idx_nxt = 2'd2;
            end else if (r_idx == 2'd2 && i_rate == c_knock_rate_3) begin
                // Index 3 is never stored: reaching it fires and restarts.
                w_detect  = 1'b1;
                w_idx_nxt = 2'd0;
            end else begin
                // A stray 200 may itself be the start of a fresh knock.
                w_idx_nxt = (i_rate == c_knock_rate_1) ? 2'd1 : 2'd0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_idx <= 2'd0;
        end else begin
            r_idx <= w_idx_nxt;
        end
    end

    assign o_detect = w_detect;

endmodule
`endif

`default_nettype wire

// File: rtl/mouse_slave_sm.sv
// ============================================================================
//  Module   : mouse_slave_sm
//  Purpose  : PS/2 mouse device-side protocol controller. Performs the
//             power-up self-test announcement, answers host commands,
//             tracks streaming/sample-rate state and forwards movement
//             reports as 3- or 4-byte packets through a byte transmitter.
//  Config   : MOUSE_SLAVE_INTELLIMOUSE_EN - enables the knock tracker, the
//             03 device ID and 4-byte wheel packets.
//  Ports    : CLK/RESET (sync, active-high); BYTE_RX_* from the receiver,
//             READ_ENABLE to it; SEND_BYTE/BYTE_TO_SEND/BYTE_SENT with the
//             transmitter; REPORT_* handshake with the movement source;
//             STREAMING/INTELLIMOUSE/SAMPLE_RATE status outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_slave_sm
    import mouse_slave_sm_pkg::*;
#(
    parameter int POWERUP_DELAY = 5000000
)
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BYTE_RX_READY,
    input  logic [7:0] BYTE_RX,
    input  logic [1:0] BYTE_RX_ERROR,
    output logic       READ_ENABLE,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    input  logic       REPORT_VALID,
    output logic       REPORT_READY,
    input  logic [7:0] REPORT_STATUS,
    input  logic [7:0] REPORT_DX,
    input  logic [7:0] REPORT_DY,
    input  logic [7:0] REPORT_DZ,
    output logic       STREAMING,
    output logic       INTELLIMOUSE,
    output logic [7:0] SAMPLE_RATE
);

    localparam int             CNT_W    = (POWERUP_DELAY > 1) ? $clog2(POWERUP_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POWERUP_DELAY - 1);

    state_t           r_state, w_state_nxt;
    state_t           r_ret,   w_ret;      // state to resume after the queue drains
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_q [4];
    logic [7:0]       w_q [4];
    logic [2:0]       r_len,   w_len;
    logic [1:0]       r_idx;
    logic [7:0]       r_tx;
    logic             r_streaming;
    logic [7:0]       r_rate;

    logic w_load, w_more, w_rx_good, w_intelli;
    logic w_set_stream, w_clr_stream, w_set_defaults, w_rate_we, w_report_ready;

    assign w_rx_good = (BYTE_RX_ERROR == 2'b00);
    assign w_more    = (({1'b0, r_idx} + 3'd1) < r_len);

    always_comb begin
        w_state_nxt    = r_state;
        w_ret          = ST_IDLE;
        w_load         = 1'b0;
        w_len          = 3'd1;
        w_q[0]         = 8'h00;
        w_q[1]         = 8'h00;
        w_q[2]         = 8'h00;
        w_q[3]         = 8'h00;
        w_set_stream   = 1'b0;
        w_clr_stream   = 1'b0;
        w_set_defaults = 1'b0;
        w_rate_we      = 1'b0;
        w_report_ready = 1'b0;

        case (r_state)
            ST_PWRUP: begin
                if (r_cnt == CNT_LAST) begin
                    w_load = 1'b1;
                    w_q[0] = c_rsp_bat_ok;
                    w_q[1] = c_id_std;
                    w_len  = 3'd2;
                end
            end
            ST_SEND: begin
                w_state_nxt = ST_WAIT_SENT;
            end
            ST_WAIT_SENT: begin
                if (BYTE_SENT) begin
                    w_state_nxt = w_more ? ST_SEND : r_ret;
                end
            end
            ST_IDLE: begin
                // Host bytes take priority; a coincident report stays pending.
                if (BYTE_RX_READY) begin
                    w_load = 1'b1;
                    if (!w_rx_good) begin
                        w_q[0] = c_rsp_resend;
                    end else begin
                        case (BYTE_RX)
                            c_cmd_reset: begin
                                w_q[0]         = c_rsp_ack;
                                w_q[1]         = c_rsp_bat_ok;
                                w_q[2]         = c_id_std;
                                w_len          = 3'd3;
                                w_clr_stream   = 1'b1;
                                w_set_defaults = 1'b1;
                            end
                            c_cmd_set_defaults: begin
                                w_q[0]         = c_rsp_ack;
                                w_clr_stream   = 1'b1;
                                w_set_defaults = 1'b1;
                            end
                            c_cmd_enable: begin
                                w_q[0]       = c_rsp_ack;
                                w_set_stream = 1'b1;
                            end
                            c_cmd_disable: begin
                                w_q[0]       = c_rsp_ack;
                                w_clr_stream = 1'b1;
                            end
                            c_cmd_set_rate: begin
                                w_q[0] = c_rsp_ack;
                                w_ret  = ST_AWAIT_RATE;
                            end
                            c_cmd_get_id: begin
                                w_q[0] = c_rsp_ack;
                                w_q[1] = w_intelli ? c_id_intelli : c_id_std;
                                w_len  = 3'd2;
                            end
                            default: begin
                                w_q[0] = c_rsp_resend;
                            end
                        endcase
                    end
                end else if (r_streaming && REPORT_VALID) begin
                    w_report_ready = 1'b1;
                    w_load         = 1'b1;
                    w_q[0]         = REPORT_STATUS | 8'h08;   // bit 3 is always-one
                    w_q[1]         = REPORT_DX;
                    w_q[2]         = REPORT_DY;
                    w_q[3]         = REPORT_DZ;
                    w_len          = w_intelli ? 3'd4 : 3'd3;
                end
            end
            ST_AWAIT_RATE: begin
                if (BYTE_RX_READY) begin
                    w_load = 1'b1;
                    if (w_rx_good) begin
                        w_q[0]    = c_rsp_ack;
                        w_rate_we = 1'b1;
                    end else begin
                        w_q[0] = c_rsp_resend;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_PWRUP;
            end
        endcase

        if (w_load) begin
            w_state_nxt = ST_SEND;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_PWRUP;
            r_ret       <= ST_IDLE;
            r_cnt       <= '0;
            r_len       <= 3'd0;
            r_idx       <= 2'd0;
            r_tx        <= 8'h00;
            r_streaming <= 1'b0;
            r_rate      <= c_default_rate;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= 8'h00;
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_PWRUP) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_q   <= w_q;
                r_len <= w_len;
                r_idx <= 2'd0;
                r_ret <= w_ret;
                r_tx  <= w_q[0];
            end else if (r_state == ST_WAIT_SENT && BYTE_SENT && w_more) begin
                r_idx <= r_idx + 2'd1;
                r_tx  <= r_q[r_idx + 2'd1];
            end
            if (w_set_stream) begin
                r_streaming <= 1'b1;
            end else if (w_clr_stream) begin
                r_streaming <= 1'b0;
            end
            if (w_set_defaults) begin
                r_rate <= c_default_rate;
            end else if (w_rate_we) begin
                r_rate <= BYTE_RX;
            end
        end
    end

`ifdef MOUSE_SLAVE_INTELLIMOUSE_EN
    logic w_knock_clr, w_knock_hit, r_intellimouse;

    // Every good host command except set-rate breaks a knock in progress.
    assign w_knock_clr = (r_state == ST_IDLE) && BYTE_RX_READY && w_rx_good &&
                         (BYTE_RX != c_cmd_set_rate);

    mouse_knock_detect u_knock (
        .CLK          (CLK),
        .RESET        (RESET),
        .i_clear      (w_knock_clr),
        .i_rate_valid (w_rate_we),
        .i_rate       (BYTE_RX),
        .o_detect     (w_knock_hit)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_intellimouse <= 1'b0;
        end else if (w_knock_clr && BYTE_RX == c_cmd_reset) begin
            r_intellimouse <= 1'b0;
        end else if (w_knock_hit) begin
            r_intellimouse <= 1'b1;
        end
    end

    assign w_intelli = r_intellimouse;
`else
    assign w_intelli = 1'b0;
`endif

    assign SEND_BYTE    = (r_state == ST_SEND);
    assign BYTE_TO_SEND = r_tx;
    assign READ_ENABLE  = (r_state == ST_IDLE) || (r_state == ST_AWAIT_RATE);
    assign REPORT_READY = w_report_ready;
    assign STREAMING    = r_streaming;
    assign INTELLIMOUSE = w_intelli;
    assign SAMPLE_RATE  = r_rate;

endmodule

`default_nettype wire

// File: tb/tb_mouse_slave_sm.sv
// ============================================================================
//  Module   : tb_mouse_slave_sm
//  Purpose  : Directed self-checking bench for mouse_slave_sm. Expected
//             transmit bytes are queued as stimulus is applied and checked
//             in order as the DUT transmits them.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mouse_slave_sm;

`ifdef MOUSE_SLAVE_INTELLIMOUSE_EN
    localparam bit INTELLI = 1'b1;
`else
    localparam bit INTELLI = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_rx_ready;
    logic [7:0] byte_rx;
    logic [1:0] byte_rx_error;
    logic       read_enable;
    logic       send_byte;
    logic [7:0] byte_to_send;
    logic       byte_sent;
    logic       report_valid;
    logic       report_ready;
    logic [7:0] report_status, report_dx, report_dy, report_dz;
    logic       streaming;
    logic       intellimouse;
    logic [7:0] sample_rate;

    int         n_vec = 0;
    int         n_err = 0;
    int         rr_cnt = 0;
    logic [7:0] sb [$];
    logic [7:0] mon_b;

    always #5 clk = ~clk;

    mouse_slave_sm #(.POWERUP_DELAY(20)) dut (
        .CLK           (clk),
        .RESET         (rst),
        .BYTE_RX_READY (byte_rx_ready),
        .BYTE_RX       (byte_rx),
        .BYTE_RX_ERROR (byte_rx_error),
        .READ_ENABLE   (read_enable),
        .SEND_BYTE     (send_byte),
        .BYTE_TO_SEND  (byte_to_send),
        .BYTE_SENT     (byte_sent),
        .REPORT_VALID  (report_valid),
        .REPORT_READY  (report_ready),
        .REPORT_STATUS (report_status),
        .REPORT_DX     (report_dx),
        .REPORT_DY     (report_dy),
        .REPORT_DZ     (report_dz),
        .STREAMING     (streaming),
        .INTELLIMOUSE  (intellimouse),
        .SAMPLE_RATE   (sample_rate)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: check each byte against the scoreboard, hold the
    // line busy for a few cycles, then acknowledge with BYTE_SENT.
    initial begin
        byte_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (send_byte === 1'b1) begin
                mon_b = byte_to_send;
                chk("tx_pending", (sb.size() > 0), 1);
                if (sb.size() > 0) chk("tx_byte", mon_b, sb.pop_front());
                repeat (3) begin
                    @(negedge clk);
                    chk("tx_hold", byte_to_send, mon_b);
                    chk("tx_single", send_byte, 0);
                    chk("rd_en_busy", read_enable, 0);
                end
                @(posedge clk) #1 byte_sent = 1'b1;
                @(posedge clk) #1 byte_sent = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (report_ready === 1'b1) begin
            rr_cnt++;
            chk("rr_streaming", streaming, 1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic host_tx(input logic [7:0] b, input logic [1:0] e);
        int n = 0;
        while (read_enable !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk("host_rd_en", read_enable, 1);
        @(posedge clk) #1;
        byte_rx = b; byte_rx_error = e; byte_rx_ready = 1'b1;
        @(posedge clk) #1;
        byte_rx_ready = 1'b0; byte_rx_error = 2'b00;
    endtask

    task automatic exch(input logic [7:0] b, input logic [7:0] r);
        sb.push_back(r);
        host_tx(b, 2'b00);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(sb.size() == 0 && read_enable === 1'b1 && byte_sent === 1'b0) && n < 2000) begin
            @(negedge clk); n++;
        end
        chk({tag, "_drain"}, (n < 2000), 1);
    endtask

    task automatic push_pkt(input logic [7:0] st, dx, dy, dz);
        sb.push_back(st | 8'h08);
        sb.push_back(dx);
        sb.push_back(dy);
        if (INTELLI) sb.push_back(dz);
    endtask

    task automatic take_report(input string tag);
        int n = 0;
        while (report_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk({tag, "_accept"}, (n < 2000), 1);
        @(posedge clk) #1;
        // Fields change after the handshake; the packet must not follow them.
        report_valid = 1'b0;
        report_status = 8'hE7; report_dx = 8'h3C; report_dy = 8'hC3; report_dz = 8'h99;
    endtask

    initial begin
        int n;
        int rr0;
        rst = 1'b1;
        byte_rx_ready = 1'b0; byte_rx = 8'h00; byte_rx_error = 2'b00;
        report_valid = 1'b0;
        report_status = 8'h00; report_dx = 8'h00; report_dy = 8'h00; report_dz = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_send_byte",    send_byte,    0);
        chk("rst_byte_to_send", byte_to_send, 8'h00);
        chk("rst_read_enable",  read_enable,  0);
        chk("rst_report_ready", report_ready, 0);
        chk("rst_streaming",    streaming,    0);
        chk("rst_intellimouse", intellimouse, 0);
        chk("rst_sample_rate",  sample_rate,  8'h64);

        // Power-up announcement
        sb.push_back(8'hAA); sb.push_back(8'h00);
        @(posedge clk) #1 rst = 1'b0;
        n = 0;
        while (send_byte !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("pwrup_delay", (n >= 20 && n <= 21), 1);
        wait_idle("pwrup");
        chk("pwrup_rd_en", read_enable, 1);

        // Sample rate store, then reset command restores defaults
        exch(8'hF3, 8'hFA); exch(8'h0A, 8'hFA); wait_idle("rate0a");
        chk("rate_0a", sample_rate, 8'h0A);
        sb.push_back(8'hFA); sb.push_back(8'hAA); sb.push_back(8'h00);
        host_tx(8'hFF, 2'b00); wait_idle("cmd_ff");
        chk("ff_rate", sample_rate, 8'h64);
        exch(8'hF4, 8'hFA); wait_idle("cmd_f4");
        chk("f4_streaming", streaming, 1);
        chk("f4_rate", sample_rate, 8'h64);

        // Broken knock sequence
        exch(8'hF3, 8'hFA); exch(8'hC8, 8'hFA);
        exch(8'hF3, 8'hFA); exch(8'h0A, 8'hFA);
        exch(8'hF3, 8'hFA); exch(8'h64, 8'hFA);
        exch(8'hF3, 8'hFA); exch(8'h50, 8'hFA);
        exch(8'hF2, 8'hFA); sb.push_back(8'h00); wait_idle("knock_bad");
        chk("knock_bad_intelli", intellimouse, 0);
        chk("knock_bad_rate", sample_rate, 8'h50);

        // Proper knock sequence
        exch(8'hF3, 8'hFA); exch(8'hC8, 8'hFA);
        exch(8'hF3, 8'hFA); exch(8'h64, 8'hFA);
        exch(8'hF3, 8'hFA); exch(8'h50, 8'hFA); wait_idle("knock");
        chk("knock_intelli", intellimouse, INTELLI);
        exch(8'hF2, 8'hFA); sb.push_back(INTELLI ? 8'h03 : 8'h00); wait_idle("get_id");
        chk("get_id_intelli", intellimouse, INTELLI);

        // Movement report
        rr0 = rr_cnt;
        push_pkt(8'h00, 8'h05, 8'hFB, 8'h01);
        @(posedge clk) #1;
        report_status = 8'h00; report_dx = 8'h05; report_dy = 8'hFB; report_dz = 8'h01;
        report_valid = 1'b1;
        take_report("rpt1");
        wait_idle("rpt1");
        chk("rpt1_rr_count", rr_cnt - rr0, 1);

        // Erroneous host byte colliding with a report: host wins
        rr0 = rr_cnt;
        sb.push_back(8'hFE);
        push_pkt(8'h31, 8'h80, 8'h7F, 8'hFF);
        @(posedge clk) #1;
        byte_rx = 8'hF4; byte_rx_error = 2'b01; byte_rx_ready = 1'b1;
        report_status = 8'h31; report_dx = 8'h80; report_dy = 8'h7F; report_dz = 8'hFF;
        report_valid = 1'b1;
        @(negedge clk);
        chk("collide_rr_low", report_ready, 0);
        @(posedge clk) #1;
        byte_rx_ready = 1'b0; byte_rx_error = 2'b00;
        take_report("rpt2");
        wait_idle("rpt2");
        chk("rpt2_rr_count", rr_cnt - rr0, 1);

        // Reports ignored while not streaming
        exch(8'hF5, 8'hFA); wait_idle("cmd_f5");
        chk("f5_streaming", streaming, 0);
        rr0 = rr_cnt;
        @(posedge clk) #1 report_valid = 1'b1;
        repeat (30) @(negedge clk);
        chk("nostream_rr", rr_cnt - rr0, 0);
        chk("nostream_idle", read_enable, 1);
        @(posedge clk) #1 report_valid = 1'b0;

        // Unknown command, then a bad byte that must change nothing
        exch(8'h12, 8'hFE); wait_idle("unknown");
        sb.push_back(8'hFE); host_tx(8'hF4, 2'b10); wait_idle("rx_err");
        chk("rx_err_streaming", streaming, 0);
        chk("rx_err_rate", sample_rate, 8'h50);

        // Set defaults keeps wheel mode; reset clears it
        exch(8'hF6, 8'hFA); wait_idle("cmd_f6");
        chk("f6_rate", sample_rate, 8'h64);
        chk("f6_intelli", intellimouse, INTELLI);
        sb.push_back(8'hFA); sb.push_back(8'hAA); sb.push_back(8'h00);
        host_tx(8'hFF, 2'b00); wait_idle("cmd_ff2");
        chk("ff2_intelli", intellimouse, 0);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
